// File: rtl/fault_pkg.sv
// Shared types and constants for the fault injector: FSM states, fault modes,
// and the random-mask LFSR polynomial/seed.
package fault_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_COUNT,
      S_INJECT,
      S_DONE
   } state_t;

   localparam logic [1:0] FM_FLIP = 2'b00;
   localparam logic [1:0] FM_SA0  = 2'b01;
   localparam logic [1:0] FM_SA1  = 2'b10;
   localparam logic [1:0] FM_RAND = 2'b11;

   // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2024;

endpackage

// File: rtl/fault_injector_if.sv
// Campaign control and replica data bus between a cipher replica and the voter.
interface fault_injector_if #(
   parameter int unsigned W  = 128,
   parameter int unsigned CW = 16
);
   logic          arm;
   logic          start;
   logic [CW-1:0] trigger_cycle;
   logic [7:0]    duration;
   logic [1:0]    fault_mode;
   logic [W-1:0]  fault_mask;
   logic [W-1:0]  data_in;
   logic [W-1:0]  data_out;
   logic          injecting;
   logic          done;
   logic [7:0]    inject_count;

   modport master (
      output arm, start, trigger_cycle, duration, fault_mode, fault_mask, data_in,
      input  data_out, injecting, done, inject_count
   );

   modport slave (
      input  arm, start, trigger_cycle, duration, fault_mode, fault_mask, data_in,
      output data_out, injecting, done, inject_count
   );
endinterface

// File: rtl/fault_lfsr.sv
// 32-bit Galois LFSR supplying the random fault mask; steps only when en is high.
module fault_lfsr
   import fault_pkg::*;
#(
   parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else if (en) begin
         q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
      end
   end

endmodule

// File: rtl/fault_injector.sv
// Registered pass-through that corrupts a timed window of replica samples.
// FAULT_INJECTOR_LFSR_EN enables the LFSR-driven random-flip mode (else mode 11 = XOR).
module fault_injector
   import fault_pkg::*;
#(
   parameter int unsigned W         = 128,
   parameter int unsigned CW        = 16,
   parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   fault_injector_if.slave bus
);

   localparam int unsigned REP = (W + 31) / 32;

   state_t        state, next_state;
   logic [CW-1:0] trig_q, cnt_q;
   logic [7:0]    rem_q, rem_c, icnt_q;
   logic [1:0]    mode_q, mode_c;
   logic [W-1:0]  mask_q, mask_c, rand_c, corrupt_c, data_q;
   logic          fault_c, start_c, inj_q, done_q;

   // fault_c marks the sample captured this edge as faulty; on the start edge
   // the live inputs are used so trigger_cycle=0 corrupts that very sample.
   always_comb begin
      next_state = state;
      fault_c    = 1'b0;
      start_c    = 1'b0;
      rem_c      = rem_q;
      mode_c     = mode_q;
      mask_c     = mask_q;
      case (state)
         S_IDLE: if (bus.arm) next_state = S_ARMED;
         S_ARMED: begin
            if (!bus.arm) begin
               next_state = S_IDLE;
            end else if (bus.start) begin
               start_c = 1'b1;
               rem_c   = bus.duration;
               mode_c  = bus.fault_mode;
               mask_c  = bus.fault_mask;
               if (bus.duration == 8'd0) begin
                  next_state = S_DONE;
               end else if (bus.trigger_cycle == CW'(0)) begin
                  fault_c    = 1'b1;
                  next_state = (bus.duration == 8'd1) ? S_DONE : S_INJECT;
               end else begin
                  next_state = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (!bus.arm) begin
               next_state = S_IDLE;
            end else if (cnt_q == trig_q) begin
               fault_c    = 1'b1;
               next_state = (rem_q == 8'd1) ? S_DONE : S_INJECT;
            end
         end
         S_INJECT: begin
            if (!bus.arm) begin
               next_state = S_IDLE;
            end else begin
               fault_c    = 1'b1;
               next_state = (rem_q == 8'd1) ? S_DONE : S_INJECT;
            end
         end
         S_DONE: if (!bus.arm) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

`ifdef FAULT_INJECTOR_LFSR_EN
   logic [31:0]        lfsr_q;
   logic [REP*32-1:0]  rep_c;

   fault_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (fault_c),
      .q   (lfsr_q)
   );

   assign rep_c  = {REP{lfsr_q}};
   assign rand_c = rep_c[W-1:0];
`else
   // All-ones random term makes mode 11 identical to XOR; the seed cannot change that.
   assign rand_c = {W{1'b1}} | W'(LFSR_SEED);
`endif

   always_comb begin
      corrupt_c = bus.data_in;
      case (mode_c)
         FM_FLIP: corrupt_c = bus.data_in ^ mask_c;
         FM_SA0:  corrupt_c = bus.data_in & ~mask_c;
         FM_SA1:  corrupt_c = bus.data_in | mask_c;
         FM_RAND: corrupt_c = bus.data_in ^ (mask_c & rand_c);
         default: corrupt_c = bus.data_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // done is withheld on the last faulty edge so it trails the last faulty output by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         inj_q  <= 1'b0;
         done_q <= 1'b0;
         icnt_q <= 8'd0;
         trig_q <= '0;
         cnt_q  <= '0;
         rem_q  <= 8'd0;
         mode_q <= FM_FLIP;
         mask_q <= '0;
      end else begin
         data_q <= fault_c ? corrupt_c : bus.data_in;
         inj_q  <= fault_c;
         done_q <= (next_state == S_DONE) && !fault_c;
         if (start_c) begin
            trig_q <= bus.trigger_cycle;
            mode_q <= mode_c;
            mask_q <= mask_c;
            cnt_q  <= CW'(1);
         end else if (state == S_COUNT) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (fault_c)      rem_q <= rem_c - 8'd1;
         else if (start_c) rem_q <= rem_c;
         if (start_c)                            icnt_q <= fault_c ? 8'd1 : 8'd0;
         else if (fault_c && icnt_q != 8'hFF)    icnt_q <= icnt_q + 8'd1;
      end
   end

   assign bus.data_out     = data_q;
   assign bus.injecting    = inj_q;
   assign bus.done         = done_q;
   assign bus.inject_count = icnt_q;

endmodule

// File: tb/tb_fault_injector.sv
// Directed self-checking bench for fault_injector; expectations are hand-computed.
module tb_fault_injector;
   import fault_pkg::*;

   localparam int unsigned W  = 128;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fault_injector_if #(.W(W), .CW(CW)) bus ();

   fault_injector #(.W(W), .CW(CW), .LFSR_SEED(32'hACE1_2024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_up();
      bus.arm = 1'b1;
      tick();
   endtask

   // Leaves the bench just after the start edge, i.e. observing start+1.
   task automatic do_start(input logic [CW-1:0] t, input logic [7:0] d,
                           input logic [1:0] m, input logic [W-1:0] mask);
      bus.start         = 1'b1;
      bus.trigger_cycle = t;
      bus.duration      = d;
      bus.fault_mode    = m;
      bus.fault_mask    = mask;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic disarm();
      bus.arm = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.arm     = 1'b1;
      bus.data_in = 128'hDEAD;
      tick();
      tick();
      n_checks++; if (bus.data_out !== 128'h0) begin n_fail++; $display("FAIL reset data_out got %h exp 0", bus.data_out); end
      n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL reset injecting got %b exp 0", bus.injecting); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", bus.done); end
      n_checks++; if (bus.inject_count !== 8'd0) begin n_fail++; $display("FAIL reset inject_count got %0d exp 0", bus.inject_count); end
      rst     = 1'b0;
      bus.arm = 1'b0;
      tick();
   endtask

   task automatic test_xor();
      logic [W-1:0] exp_d;
      bus.data_in = 128'hA5;
      arm_up();
      do_start(CW'(3), 8'd2, FM_FLIP, 128'h1);
      for (int k = 1; k <= 6; k++) begin
         exp_d = (k == 4 || k == 5) ? 128'hA4 : 128'hA5;
         n_checks++; if (bus.data_out !== exp_d) begin n_fail++; $display("FAIL xor data start+%0d got %h exp %h", k, bus.data_out, exp_d); end
         n_checks++; if (bus.injecting !== (k == 4 || k == 5)) begin n_fail++; $display("FAIL xor injecting start+%0d got %b", k, bus.injecting); end
         n_checks++; if (bus.done !== (k == 6)) begin n_fail++; $display("FAIL xor done start+%0d got %b", k, bus.done); end
         if (k < 6) tick();
      end
      n_checks++; if (bus.inject_count !== 8'd2) begin n_fail++; $display("FAIL xor inject_count got %0d exp 2", bus.inject_count); end
      disarm();
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL xor done after disarm got %b exp 0", bus.done); end
   endtask

   task automatic test_stuck_at_1();
      bus.data_in = '0;
      arm_up();
      do_start(CW'(0), 8'd1, FM_SA1, 128'hFF00);
      n_checks++; if (bus.data_out !== 128'hFF00) begin n_fail++; $display("FAIL sa1 data start+1 got %h exp ff00", bus.data_out); end
      n_checks++; if (bus.injecting !== 1'b1) begin n_fail++; $display("FAIL sa1 injecting start+1 got %b exp 1", bus.injecting); end
      tick();
      n_checks++; if (bus.data_out !== 128'h0) begin n_fail++; $display("FAIL sa1 data start+2 got %h exp 0", bus.data_out); end
      n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL sa1 injecting start+2 got %b exp 0", bus.injecting); end
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL sa1 done start+2 got %b exp 1", bus.done); end
      n_checks++; if (bus.inject_count !== 8'd1) begin n_fail++; $display("FAIL sa1 inject_count got %0d exp 1", bus.inject_count); end
      disarm();
   endtask

   task automatic test_zero_duration();
      logic [W-1:0] exp_d;
      bus.data_in = 128'h11;
      arm_up();
      do_start(CW'(0), 8'd0, FM_FLIP, '1);
      n_checks++; if (bus.data_out !== 128'h11) begin n_fail++; $display("FAIL d0 data start+1 got %h exp 11", bus.data_out); end
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL d0 done start+1 got %b exp 1", bus.done); end
      for (int j = 0; j < 4; j++) begin
         exp_d       = 128'h100 + W'(j);
         bus.data_in = exp_d;
         tick();
         n_checks++; if (bus.data_out !== exp_d) begin n_fail++; $display("FAIL d0 data step %0d got %h exp %h", j, bus.data_out, exp_d); end
         n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL d0 injecting step %0d got %b exp 0", j, bus.injecting); end
      end
      n_checks++; if (bus.inject_count !== 8'd0) begin n_fail++; $display("FAIL d0 inject_count got %0d exp 0", bus.inject_count); end
      disarm();
   endtask

   task automatic test_abort();
      bus.data_in = 128'hA5;
      arm_up();
      do_start(CW'(0), 8'd10, FM_FLIP, 128'h0F);
      for (int k = 1; k <= 4; k++) begin
         n_checks++; if (bus.data_out !== 128'hAA) begin n_fail++; $display("FAIL abort data start+%0d got %h exp aa", k, bus.data_out); end
         n_checks++; if (bus.inject_count !== 8'(k)) begin n_fail++; $display("FAIL abort count start+%0d got %0d exp %0d", k, bus.inject_count, k); end
         if (k < 4) tick();
      end
      bus.arm = 1'b0;
      for (int k = 5; k <= 6; k++) begin
         tick();
         n_checks++; if (bus.data_out !== 128'hA5) begin n_fail++; $display("FAIL abort passthrough start+%0d got %h exp a5", k, bus.data_out); end
         n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL abort injecting start+%0d got %b exp 0", k, bus.injecting); end
         n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort done start+%0d got %b exp 0", k, bus.done); end
         n_checks++; if (bus.inject_count !== 8'd4) begin n_fail++; $display("FAIL abort retained count got %0d exp 4", bus.inject_count); end
      end
      // Back in IDLE: a fresh arm/start campaign must work.
      arm_up();
      do_start(CW'(0), 8'd1, FM_SA0, 128'h0F);
      n_checks++; if (bus.data_out !== 128'hA0) begin n_fail++; $display("FAIL abort rearm sa0 got %h exp a0", bus.data_out); end
      disarm();
   endtask

   task automatic test_reset_mid_count();
      bus.data_in = 128'h5A;
      arm_up();
      do_start(CW'(20), 8'd2, FM_FLIP, 128'hFF);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (bus.data_out !== 128'h0) begin n_fail++; $display("FAIL midrst data got %h exp 0", bus.data_out); end
      n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL midrst injecting got %b exp 0", bus.injecting); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst done got %b exp 0", bus.done); end
      n_checks++; if (bus.inject_count !== 8'd0) begin n_fail++; $display("FAIL midrst inject_count got %0d exp 0", bus.inject_count); end
      // Start with arm low, then arm and start together: both arrive in IDLE and must be ignored.
      bus.arm = 1'b0;
      do_start(CW'(0), 8'd1, FM_FLIP, 128'hFF);
      bus.arm = 1'b1;
      do_start(CW'(0), 8'd1, FM_FLIP, 128'hFF);
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (bus.data_out !== 128'h5A) begin n_fail++; $display("FAIL midrst ignored start step %0d got %h exp 5a", k, bus.data_out); end
         n_checks++; if (bus.injecting !== 1'b0) begin n_fail++; $display("FAIL midrst ignored injecting step %0d got %b", k, bus.injecting); end
         tick();
      end
      do_start(CW'(0), 8'd1, FM_FLIP, 128'hFF);
      n_checks++; if (bus.data_out !== 128'hA5) begin n_fail++; $display("FAIL midrst rearmed data got %h exp a5", bus.data_out); end
      disarm();
   endtask

   task automatic test_random();
      logic [31:0]  lv [3];
      logic [W-1:0] exp_d;
      lv[0] = 32'hACE1_2024;
      lv[1] = 32'h5670_9012;
      lv[2] = 32'h2B38_4809;
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      bus.data_in = '0;
      arm_up();
      do_start(CW'(0), 8'd3, FM_RAND, '1);
      for (int k = 0; k < 3; k++) begin
`ifdef FAULT_INJECTOR_LFSR_EN
         exp_d = {4{lv[k]}};
`else
         exp_d = '1;
`endif
         n_checks++; if (bus.data_out !== exp_d) begin n_fail++; $display("FAIL rand data sample %0d got %h exp %h", k, bus.data_out, exp_d); end
         n_checks++; if (bus.injecting !== 1'b1) begin n_fail++; $display("FAIL rand injecting sample %0d got %b exp 1", k, bus.injecting); end
         tick();
      end
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rand done got %b exp 1", bus.done); end
      disarm();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      bus.arm           = 1'b0;
      bus.start         = 1'b0;
      bus.trigger_cycle = '0;
      bus.duration      = 8'd0;
      bus.fault_mode    = FM_FLIP;
      bus.fault_mask    = '0;
      bus.data_in       = '0;
      test_reset();
      test_xor();
      test_stuck_at_1();
      test_zero_duration();
      test_abort();
      test_reset_mid_count();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
